// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
// The PC is word-addressed and wraps modulo the ROM depth.
package cpu_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic pc_at_top(input logic [ADDR_W-1:0] pc);
    return pc == {ADDR_W{1'b1}};
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus: ROM port, redirect input and the decode handshake.
// master = fetch controller, slave = ROM/decode/branch environment.
interface inst_fetch_ctrl_if;
  import cpu_pkg::*;

  logic              fetch_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic              pc_wrap;

  modport master (
    input  fetch_en, rom_inst, redir_valid, redir_pc, id_ready,
    output rom_addr, id_valid, id_inst, id_pc, pc_wrap
  );

  modport slave (
    output fetch_en, rom_inst, redir_valid, redir_pc, id_ready,
    input  rom_addr, id_valid, id_inst, id_pc, pc_wrap
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO with flush; slot0 is always the registered head.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;

  // Next-state for slots and occupancy; flush wins over push/pop.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_d = push_data;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            slot1_d = push_data;
            count_d = 2'd2;
          end else begin
            count_d = count_q;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            slot0_d = slot1_q;
          end else begin
            slot0_d = slot0_q;
          end
          count_d = (count_q == 2'd0) ? 2'd0 : count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the older entry moves up, occupancy unchanged.
          if (count_q == 2'd2) begin
            slot0_d = slot1_q;
            slot1_d = push_data;
          end else begin
            slot0_d = push_data;
          end
          count_d = count_q;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Queue storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '{pc: {ADDR_W{1'b0}}, inst: {DATA_W{1'b0}}};
      slot1_q <= '{pc: {ADDR_W{1'b0}}, inst: {DATA_W{1'b0}}};
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head       = slot0_q;
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the ROM, and feeds decode through
// the 2-entry fetch queue. Redirect flushes the queue and reloads the PC.
module inst_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_ctrl_if.master  bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_wrap_q, pc_wrap_d;

  logic              push_s;
  logic              pop_s;
  logic              q_valid_s;
  logic [1:0]        q_count_s;
  fetch_entry_t      head_s;
  fetch_entry_t      push_entry_s;

  assign pop_s        = q_valid_s & bus.id_ready;
  assign push_s       = (state_q == RUN) & ~bus.redir_valid & ((q_count_s != 2'd2) | pop_s);
  assign push_entry_s = '{pc: pc_q, inst: bus.rom_inst};

  // PC, wrap pulse and run/idle next-state; redirect outranks everything.
  always_comb begin
    pc_d      = pc_q;
    pc_wrap_d = 1'b0;
    state_d   = state_q;
    if (bus.redir_valid) begin
      pc_d = bus.redir_pc;
    end else if (push_s) begin
      pc_d      = pc_inc(pc_q);
      pc_wrap_d = pc_at_top(pc_q);
    end else begin
      pc_d = pc_q;
    end
    case (state_q)
      IDLE:    state_d = (bus.fetch_en && !bus.redir_valid) ? RUN : IDLE;
      RUN:     state_d = (!bus.fetch_en && !bus.redir_valid) ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pc_wrap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_wrap_q <= pc_wrap_d;
    end
  end

  fetch_queue u_fetch_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (bus.redir_valid),
    .push_data  (push_entry_s),
    .head       (head_s),
    .head_valid (q_valid_s),
    .count      (q_count_s)
  );

  assign bus.rom_addr = pc_q;
  assign bus.id_valid = q_valid_s;
  assign bus.id_inst  = head_s.inst;
  assign bus.id_pc    = head_s.pc;
  assign bus.pc_wrap  = pc_wrap_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: a queue-based reference model predicts
// the decode stream, a negedge monitor compares every cycle against it.
module tb_inst_fetch_ctrl;

  logic clk;
  logic rst_n;

  inst_fetch_ctrl_if bus_if ();

  inst_fetch_ctrl #(.RESET_PC(6'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // ROM: word i = A500_0000 + i
  assign bus_if.rom_inst = 32'hA500_0000 + {26'd0, bus_if.rom_addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks   = 0;
  int n_errors   = 0;
  int wrap_seen  = 0;

  // reference model state: expected decode queue, PC, run flag, wrap pulse
  int unsigned eq_pc[$];
  logic [31:0] eq_inst[$];
  int unsigned m_pc   = 0;
  bit          m_run  = 1'b0;
  bit          m_wrap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    eq_pc.delete();
    eq_inst.delete();
    m_pc   = 0;
    m_run  = 1'b0;
    m_wrap = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs presented for it.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_wrap = 1'b0;
      if (bus_if.redir_valid) begin
        eq_pc.delete();
        eq_inst.delete();
        m_pc = int'(bus_if.redir_pc);
      end else begin
        // queue room counts an entry leaving this cycle (already popped by the monitor)
        if (m_run && eq_pc.size() < 2) begin
          eq_pc.push_back(m_pc);
          eq_inst.push_back(32'hA500_0000 + 32'(m_pc));
          m_wrap = (m_pc == 63);
          m_pc   = (m_pc + 1) % 64;
        end
        m_run = bus_if.fetch_en;
      end
    end
  endtask

  task automatic step(input logic fe, input logic rdy, input logic rv, input logic [5:0] rpc);
    bus_if.fetch_en    = fe;
    bus_if.id_ready    = rdy;
    bus_if.redir_valid = rv;
    bus_if.redir_pc    = rpc;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compare outputs against the model; retire the head on handshake.
  initial begin
    forever begin
      @(negedge clk);
      chk("id_valid", 32'(bus_if.id_valid), 32'(eq_pc.size() != 0));
      chk("rom_addr", 32'(bus_if.rom_addr), 32'(m_pc));
      chk("pc_wrap", 32'(bus_if.pc_wrap), 32'(m_wrap));
      if (eq_pc.size() != 0) begin
        chk("id_pc", 32'(bus_if.id_pc), 32'(eq_pc[0]));
        chk("id_inst", bus_if.id_inst, eq_inst[0]);
        if (bus_if.id_ready) begin
          void'(eq_pc.pop_front());
          void'(eq_inst.pop_front());
        end
      end
      if (bus_if.pc_wrap) wrap_seen++;
    end
  end

  initial begin
    int wrap0;
    bus_if.fetch_en    = 1'b0;
    bus_if.id_ready    = 1'b0;
    bus_if.redir_valid = 1'b0;
    bus_if.redir_pc    = 6'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 6'd0);
    step(1'b0, 1'b0, 1'b0, 6'd0);
    chk("rst_id_valid", 32'(bus_if.id_valid), 32'h0);
    chk("rst_id_pc", 32'(bus_if.id_pc), 32'h0);
    chk("rst_id_inst", bus_if.id_inst, 32'h0);
    chk("rst_pc_wrap", 32'(bus_if.pc_wrap), 32'h0);
    chk("rst_rom_addr", 32'(bus_if.rom_addr), 32'h0);
    rst_n = 1'b1;

    // streaming from reset
    step(1'b1, 1'b1, 1'b0, 6'd0);
    step(1'b1, 1'b1, 1'b0, 6'd0);
    chk("s1_valid", 32'(bus_if.id_valid), 32'h1);
    chk("s1_pc0", 32'(bus_if.id_pc), 32'h0);
    chk("s1_inst0", bus_if.id_inst, 32'hA500_0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 6'd0);
    chk("s1_pc4", 32'(bus_if.id_pc), 32'h4);

    // stall with head at pc 4
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 6'd0);
    chk("s2_rom_addr_held", 32'(bus_if.rom_addr), 32'h6);
    chk("s2_id_pc_held", 32'(bus_if.id_pc), 32'h4);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 6'd0);

    // redirect while full
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b0, 1'b1, 6'h20);
    chk("s3_flush_valid", 32'(bus_if.id_valid), 32'h0);
    step(1'b1, 1'b1, 1'b0, 6'd0);
    chk("s3_target_valid", 32'(bus_if.id_valid), 32'h1);
    chk("s3_target_pc", 32'(bus_if.id_pc), 32'h20);
    chk("s3_target_inst", bus_if.id_inst, 32'hA500_0020);

    // wrap at the ROM boundary
    step(1'b1, 1'b1, 1'b1, 6'h3E);
    wrap0 = wrap_seen;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 6'd0);
    chk("s4_wrap_once", 32'(wrap_seen - wrap0), 32'h1);

    // fetch disable with a full queue, drain, then resume
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 6'd0);
    chk("s5_drained", 32'(bus_if.id_valid), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 6'd0);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_async_valid", 32'(bus_if.id_valid), 32'h0);
    chk("s6_async_pc", 32'(bus_if.rom_addr), 32'h0);
    step(1'b1, 1'b1, 1'b0, 6'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 6'd0);
    step(1'b1, 1'b1, 1'b0, 6'd0);
    chk("s6_restart_valid", 32'(bus_if.id_valid), 32'h1);
    chk("s6_restart_pc", 32'(bus_if.id_pc), 32'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(logic'($urandom_range(0, 9) != 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 19) == 0),
           6'($urandom_range(0, 63)));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 6'd0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
